// File: rtl/alu_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_div_sequencer
// Purpose : RV32M DIV/DIVU/REM/REMU by restoring division. All subtractions
//           and negations are done on the shared execute-stage ALU.
// Revision: 1.0 - initial release
// ============================================================================
module alu_div_sequencer #(
  parameter int         XLEN    = 32,
  parameter logic [5:0] ALU_SUB = 6'd1,
  parameter logic [5:0] ALU_ADD = 6'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_srca,
  output logic [XLEN-1:0] alu_srcb,
  output logic [5:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_out
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NEGA = 3'd1,
    S_NEGB = 3'd2,
    S_ITER = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            rem_q, rem_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;     // raw divisor, replaced by |B| in NEGB
  logic [XLEN-1:0] r_q, r_d;     // remainder; its 33rd bit is always zero between steps
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN:0]   s_val;
  logic            step_ok;
  logic [XLEN-1:0] fix_sel;
  logic            fix_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    alu_req  = 1'b0;
    alu_srca = '0;
    alu_srcb = '0;
    alu_ctrl = ALU_ADD;

    s_val   = {r_q, quo_q[XLEN-1]};
    step_ok = s_val[XLEN] | (s_val[XLEN-1:0] >= b_q);
    fix_sel = rem_q ? r_q : quo_q;
    fix_neg = rem_q ? neg_a_q : (neg_a_q ^ neg_b_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = op[1];
          a_d     = dividend;
          b_d     = divisor;
          neg_a_d = ~op[0] & dividend[XLEN-1];
          neg_b_d = ~op[0] & divisor[XLEN-1];
          if (divisor == '0) begin
            result_d = op[1] ? dividend : '1;
            state_d  = S_DONE;
          end else if (~op[0] && dividend == SMIN && divisor == '1) begin
            result_d = op[1] ? '0 : SMIN;
            state_d  = S_DONE;
          end else begin
            state_d = S_NEGA;
          end
        end
      end
      S_NEGA: begin
        alu_req  = 1'b1;
        alu_srcb = a_q;
        alu_ctrl = ALU_SUB;
        if (alu_gnt) begin
          quo_d   = neg_a_q ? alu_out : a_q;
          state_d = S_NEGB;
        end
      end
      S_NEGB: begin
        alu_req  = 1'b1;
        alu_srcb = b_q;
        alu_ctrl = ALU_SUB;
        if (alu_gnt) begin
          b_d     = neg_b_q ? alu_out : b_q;
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        alu_req  = 1'b1;
        alu_srca = s_val[XLEN-1:0];
        alu_srcb = b_q;
        alu_ctrl = ALU_SUB;
        if (alu_gnt) begin
          // A set 33rd bit means S exceeds any 32-bit divisor.
          r_d   = step_ok ? alu_out : s_val[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], step_ok};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        alu_req  = 1'b1;
        alu_srcb = fix_sel;
        alu_ctrl = ALU_SUB;
        if (alu_gnt) begin
          result_d = fix_neg ? alu_out : fix_sel;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush abandons the operation and also blocks a same-cycle start.
    if (kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
`default_nettype wire
